dpll_nco_phase_detector: RTL and testbench

- Digitally-controlled oscillator (NCO) plus phase detector for the FluxRipper DPLL. It closes the loop around the PI loop filter.
- Consumes the filter's signed phase_adj as a frequency correction and generates bit-cell timing.
- On each flux edge it measures the edge position against cell centre and emits phase_error / error_valid / margin_zone back to the filter and bandwidth controller.
- Also produces decoded cell data, a cell strobe and pll_locked.

---
 rtl/dpll_pkg.sv | 31 +++
 rtl/dpll_lock_detect.sv | 62 ++++++
 rtl/dpll_nco_phase_detector.sv | 144 ++++++++++++++
 tb/tb_dpll_nco_phase_detector.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// Shared definitions for the FluxRipper DPLL NCO / phase detector.
// Margin-zone codes, zone thresholds and the lock state encoding.
package dpll_pkg;

  localparam logic [1:0] MZ_EARLY    = 2'b00;
  localparam logic [1:0] MZ_ONTIME   = 2'b01;
  localparam logic [1:0] MZ_LATE     = 2'b10;
  localparam logic [1:0] MZ_MARGINAL = 2'b11;

  localparam logic [15:0] MZ_NEAR_TH = 16'h2000;
  localparam logic [15:0] MZ_FAR_TH  = 16'h6000;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_e;

  // |err| saturates so that -0x8000 reads as 0x7FFF
  function automatic logic [1:0] zone_of(input logic [15:0] err);
    logic [15:0] mag;
    logic [1:0]  z;
    mag = err[15] ? (16'h0000 - err) : err;
    if (mag[15]) mag = 16'h7FFF;
    if (mag >= MZ_FAR_TH)     z = MZ_MARGINAL;
    else if (mag < MZ_NEAR_TH) z = MZ_ONTIME;
    else if (err[15])          z = MZ_EARLY;
    else                       z = MZ_LATE;
    return z;
  endfunction

endpackage

// File: rtl/dpll_lock_detect.sv
// DPLL lock detector: counts consecutive on-time / off-time edges
// to enter and leave the locked state.
module dpll_lock_detect
  import dpll_pkg::*;
#(
  parameter int LOCK_COUNT   = 32,
  parameter int UNLOCK_COUNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_zone,
  input  logic       i_error_valid,
  input  logic       i_clear,
  output logic       o_locked
);

  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [LW-1:0] LMAX = LW'(LOCK_COUNT);
  localparam logic [UW-1:0] UMAX = UW'(UNLOCK_COUNT);

  lock_state_e   r_state;
  logic [LW-1:0] r_lock_cnt;
  logic [UW-1:0] r_unlock_cnt;
  logic          w_ontime;

  assign w_ontime = (i_zone == MZ_ONTIME);
  assign o_locked = (r_state == LK_LOCKED);

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_state      <= LK_UNLOCKED;
      r_lock_cnt   <= '0;
      r_unlock_cnt <= '0;
    end else if (i_error_valid) begin
      case (r_state)
        LK_UNLOCKED: begin
          if (!w_ontime) begin
            r_lock_cnt <= '0;
          end else if (r_lock_cnt != LMAX) begin
            r_lock_cnt <= r_lock_cnt + LW'(1);
            if (r_lock_cnt == LMAX - LW'(1))
              r_state <= LK_LOCKED;
          end
        end
        LK_LOCKED: begin
          if (w_ontime) begin
            r_unlock_cnt <= '0;
          end else if (r_unlock_cnt == UMAX - UW'(1)) begin
            r_state      <= LK_UNLOCKED;
            r_lock_cnt   <= '0;
            r_unlock_cnt <= '0;
          end else begin
            r_unlock_cnt <= r_unlock_cnt + UW'(1);
          end
        end
        default: r_state <= LK_UNLOCKED;
      endcase
    end
  end

endmodule

// File: rtl/dpll_nco_phase_detector.sv
// NCO + flux-edge phase detector closing the FluxRipper DPLL loop.
// Optional edge deglitch filter: define DPLL_EDGE_DEGLITCH_EN.
module dpll_nco_phase_detector
  import dpll_pkg::*;
#(
  parameter int PHASE_W      = 24,
  parameter int ADJ_SHIFT    = 2,
  parameter int LOCK_COUNT   = 32,
  parameter int UNLOCK_COUNT = 8
`ifdef DPLL_EDGE_DEGLITCH_EN
  ,
  parameter int DEGLITCH_CYCLES = 8
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               flux_edge,
  input  logic [PHASE_W-1:0] nominal_inc,
  input  logic [15:0]        phase_adj,
  input  logic               phase_adj_valid,
  input  logic               rate_change,
  output logic [15:0]        phase_error,
  output logic               error_valid,
  output logic [1:0]         margin_zone,
  output logic               cell_strobe,
  output logic               data_bit,
  output logic               pll_locked
);

  localparam int XW = PHASE_W + 2;

  logic [PHASE_W-1:0] r_acc;
  logic [15:0]        r_adj;
  logic               r_edge_seen;
  logic [15:0]        r_err;
  logic               r_ev;
  logic [1:0]         r_zone;
  logic               r_cs;
  logic               r_db;

  logic signed [XW-1:0] w_nom;
  logic signed [XW-1:0] w_adj;
  logic signed [XW-1:0] w_sum;
  logic signed [XW-1:0] w_lo;
  logic signed [XW-1:0] w_hi;
  logic signed [XW-1:0] w_inc;
  logic [XW-1:0]        w_nxt;
  logic                 w_carry;
  logic                 w_cell_end;
  logic [15:0]          w_raw;
  logic [15:0]          w_err;
  logic                 w_gap_ok;
  logic                 w_edge;

  assign w_nom = $signed({2'b00, nominal_inc});
  assign w_adj = $signed({{(XW-16){r_adj[15]}}, r_adj}) >>> ADJ_SHIFT;
  assign w_sum = w_nom + w_adj;
  assign w_lo  = w_nom - (w_nom >>> 3);
  assign w_hi  = w_nom + (w_nom >>> 3);

  always_comb begin
    w_inc = w_sum;
    if (w_sum < w_lo)      w_inc = w_lo;
    else if (w_sum > w_hi) w_inc = w_hi;
  end

  // Wide add: any bit above PHASE_W is the cell-boundary carry
  assign w_nxt      = {2'b00, r_acc} + w_inc;
  assign w_carry    = |w_nxt[XW-1:PHASE_W];
  assign w_cell_end = enable & w_carry;

  assign w_raw = r_acc[PHASE_W-1 -: 16];
  assign w_err = {~w_raw[15], w_raw[14:0]};

`ifdef DPLL_EDGE_DEGLITCH_EN
  localparam int DW = $clog2(DEGLITCH_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEGLITCH_CYCLES);

  logic [DW-1:0] r_since;

  assign w_gap_ok = (r_since >= DMAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_since <= DMAX;
    end else if (enable) begin
      if (flux_edge && w_gap_ok) r_since <= DW'(1);
      else if (!w_gap_ok)        r_since <= r_since + DW'(1);
    end
  end
`else
  assign w_gap_ok = 1'b1;
`endif

  assign w_edge = enable & flux_edge & w_gap_ok & ~r_edge_seen;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_adj       <= '0;
      r_edge_seen <= 1'b0;
      r_err       <= '0;
      r_ev        <= 1'b0;
      r_zone      <= '0;
      r_cs        <= 1'b0;
      r_db        <= 1'b0;
    end else begin
      if (rate_change)          r_adj <= '0;
      else if (phase_adj_valid) r_adj <= phase_adj;
      r_ev <= w_edge;
      r_cs <= w_cell_end;
      r_db <= w_cell_end & (r_edge_seen | w_edge);
      if (w_edge) begin
        r_err  <= w_err;
        r_zone <= zone_of(w_err);
      end
      if (enable) begin
        r_acc <= w_nxt[PHASE_W-1:0];
        if (w_cell_end)  r_edge_seen <= 1'b0;
        else if (w_edge) r_edge_seen <= 1'b1;
      end
    end
  end

  assign phase_error = r_err;
  assign error_valid = r_ev;
  assign margin_zone = r_zone;
  assign cell_strobe = r_cs;
  assign data_bit    = r_db;

  dpll_lock_detect #(
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (UNLOCK_COUNT)
  ) u_lock (
    .clk           (clk),
    .reset         (reset),
    .i_zone        (r_zone),
    .i_error_valid (r_ev),
    .i_clear       (rate_change),
    .o_locked      (pll_locked)
  );

endmodule

// File: tb/tb_dpll_nco_phase_detector.sv
// Directed bench for dpll_nco_phase_detector; a tiny accumulator
// model tracks expected edge phase, key values are hand-computed.
module tb_dpll_nco_phase_detector;
  import dpll_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        flux_edge = 1'b0;
  logic [23:0] nominal_inc = 24'd83886;
  logic [15:0] phase_adj = 16'h0000;
  logic        phase_adj_valid = 1'b0;
  logic        rate_change = 1'b0;
  logic [15:0] phase_error;
  logic        error_valid;
  logic [1:0]  margin_zone;
  logic        cell_strobe;
  logic        data_bit;
  logic        pll_locked;

  int checks = 0;
  int failures = 0;

  int unsigned m_acc = 0;
  int unsigned m_inc = 83886;
  bit          m_carry = 0;
  logic        lk_at_ev = 1'b0;
  logic        lk_after = 1'b0;
  logic [15:0] last_err = 16'h0000;

  always #5 clk = ~clk;

  dpll_nco_phase_detector dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .flux_edge       (flux_edge),
    .nominal_inc     (nominal_inc),
    .phase_adj       (phase_adj),
    .phase_adj_valid (phase_adj_valid),
    .rate_change     (rate_change),
    .phase_error     (phase_error),
    .error_valid     (error_valid),
    .margin_zone     (margin_zone),
    .cell_strobe     (cell_strobe),
    .data_bit        (data_bit),
    .pll_locked      (pll_locked)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    m_carry = 0;
    if (reset) begin
      m_acc = 0;
    end else if (enable) begin
      m_carry = (m_acc + m_inc) >= 32'h0100_0000;
      m_acc = (m_acc + m_inc) & 32'h00FF_FFFF;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    flux_edge = 1'b0;
    phase_adj_valid = 1'b0;
    rate_change = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  // off<0: edge placed in the carry cycle of the cell
  task automatic run_cell(input int off, input int nedge,
                          input logic [1:0] zexp, input logic exp_db,
                          input int pos0);
    int pos;
    int evn;
    int csbad;
    bit done;
    bit fe;
    bit taken;
    bit want_lk;
    logic [15:0] exp_raw;
    logic [15:0] exp_err;
    pos = pos0;
    evn = 0;
    csbad = 0;
    done = 0;
    taken = 0;
    want_lk = 0;
    exp_raw = 16'h0000;
    while (!done) begin
      if (off < 0) fe = (m_acc + m_inc) >= 32'h0100_0000;
      else fe = (nedge > 0 && pos == off) || (nedge == 2 && pos == off + 5);
      if (fe && !taken) begin
        exp_raw = m_acc[23:8];
        taken = 1;
      end
      flux_edge = fe;
      cyc();
      flux_edge = 1'b0;
      if (want_lk) begin
        lk_after = pll_locked;
        want_lk = 0;
      end
      if (error_valid) begin
        evn++;
        if (evn == 1) begin
          exp_err = exp_raw - 16'h8000;
          last_err = phase_error;
          lk_at_ev = pll_locked;
          want_lk = 1;
          checks++;
          if (phase_error !== exp_err || margin_zone !== zexp) begin
            failures++;
            $display("FAIL cell_err off=%0d got err=%h zone=%b want err=%h zone=%b",
                     off, phase_error, margin_zone, exp_err, zexp);
          end
        end
      end
      if (cell_strobe !== m_carry) csbad++;
      if (m_carry) begin
        done = 1;
        checks++;
        if (data_bit !== exp_db) begin
          failures++;
          $display("FAIL data_bit off=%0d got %b want %b", off, data_bit, exp_db);
        end
      end
      pos++;
      if (pos > 500) begin
        checks++;
        failures++;
        $display("FAIL cell_timeout off=%0d no cell_strobe within bound", off);
        done = 1;
      end
    end
    checks++;
    if (evn != ((nedge > 0) ? 1 : 0) || csbad != 0) begin
      failures++;
      $display("FAIL cell_strobes off=%0d got ev=%0d strobe_err=%0d want ev=%0d strobe_err=0",
               off, evn, csbad, (nedge > 0) ? 1 : 0);
    end
  endtask

  task automatic edge_at(input int k, input logic [15:0] exp_err,
                         input logic [1:0] zexp);
    enable = 1'b1;
    repeat (k) cyc();
    flux_edge = 1'b1;
    cyc();
    flux_edge = 1'b0;
    checks++;
    if (error_valid !== 1'b1 || phase_error !== exp_err || margin_zone !== zexp) begin
      failures++;
      $display("FAIL clamp_edge got ev=%b err=%h zone=%b want ev=1 err=%h zone=%b",
               error_valid, phase_error, margin_zone, exp_err, zexp);
    end
  endtask

  task automatic test_reset();
    int n;
    int evbad;
    nominal_inc = 24'd83886;
    m_inc = 83886;
    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      flux_edge = i[0];
      cyc();
    end
    flux_edge = 1'b0;
    checks++;
    if ({phase_error, error_valid, margin_zone, cell_strobe, data_bit, pll_locked} !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs got %h want 0",
               {phase_error, error_valid, margin_zone, cell_strobe, data_bit, pll_locked});
    end
    reset = 1'b0;
    n = 0;
    evbad = 0;
    while (n < 400) begin
      cyc();
      n++;
      if (error_valid) evbad++;
      if (cell_strobe) break;
    end
    checks++;
    if (n != 201 || evbad != 0 || data_bit !== 1'b0) begin
      failures++;
      $display("FAIL first_strobe got n=%0d ev=%0d db=%b want n=201 ev=0 db=0",
               n, evbad, data_bit);
    end
  endtask

  task automatic test_lock();
    run_cell(100, 1, MZ_ONTIME, 1'b1, 0);
    checks++;
    if (last_err !== 16'h0147) begin
      failures++;
      $display("FAIL first_ontime_err got %h want 0147", last_err);
    end
    repeat (30) run_cell(100, 1, MZ_ONTIME, 1'b1, 0);
    checks++;
    if (pll_locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_early got %b want 0 after 31 edges", pll_locked);
    end
    run_cell(100, 1, MZ_ONTIME, 1'b1, 0);
    checks++;
    if (lk_at_ev !== 1'b0 || lk_after !== 1'b1) begin
      failures++;
      $display("FAIL lock_rise got at_ev=%b after=%b want 0 1", lk_at_ev, lk_after);
    end
  endtask

  task automatic test_zones();
    run_cell(60, 1, MZ_EARLY, 1'b1, 0);
    run_cell(150, 1, MZ_LATE, 1'b1, 0);
    run_cell(195, 1, MZ_MARGINAL, 1'b1, 0);
    run_cell(100, 1, MZ_ONTIME, 1'b1, 0);
    checks++;
    if (pll_locked !== 1'b1) begin
      failures++;
      $display("FAIL zones_hold_lock got %b want 1", pll_locked);
    end
  endtask

  task automatic test_unlock();
    repeat (7) run_cell(60, 1, MZ_EARLY, 1'b1, 0);
    checks++;
    if (pll_locked !== 1'b1) begin
      failures++;
      $display("FAIL unlock_early got %b want 1 after 7 bad edges", pll_locked);
    end
    run_cell(60, 1, MZ_EARLY, 1'b1, 0);
    checks++;
    if (pll_locked !== 1'b0) begin
      failures++;
      $display("FAIL unlock got %b want 0 after 8 bad edges", pll_locked);
    end
  endtask

  task automatic test_carry_edge();
    run_cell(-1, 1, MZ_MARGINAL, 1'b1, 0);
    run_cell(100, 1, MZ_ONTIME, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    run_cell(100, 2, MZ_ONTIME, 1'b1, 0);
  endtask

  task automatic test_enable();
    int bad;
    bad = 0;
    repeat (30) cyc();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      flux_edge = (i == 4);
      cyc();
      if (error_valid || cell_strobe || data_bit) bad++;
    end
    flux_edge = 1'b0;
    enable = 1'b1;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL enable_low got %0d strobes want 0", bad);
    end
    run_cell(100, 1, MZ_ONTIME, 1'b1, 30);
  endtask

  task automatic test_rate_change();
    repeat (32) run_cell(100, 1, MZ_ONTIME, 1'b1, 0);
    checks++;
    if (pll_locked !== 1'b1) begin
      failures++;
      $display("FAIL relock got %b want 1", pll_locked);
    end
    repeat (50) cyc();
    phase_adj = 16'h7FFF;
    phase_adj_valid = 1'b1;
    rate_change = 1'b1;
    cyc();
    phase_adj_valid = 1'b0;
    rate_change = 1'b0;
    checks++;
    if (pll_locked !== 1'b0) begin
      failures++;
      $display("FAIL rate_change_unlock got %b want 0", pll_locked);
    end
    run_cell(100, 1, MZ_ONTIME, 1'b1, 51);
    run_cell(100, 1, MZ_ONTIME, 1'b1, 0);
    checks++;
    if (pll_locked !== 1'b0) begin
      failures++;
      $display("FAIL rate_change_stay got %b want 0", pll_locked);
    end
  endtask

  task automatic test_clamp();
    nominal_inc = 24'd40000;
    do_reset();
    phase_adj = 16'h7FFF;
    phase_adj_valid = 1'b1;
    cyc();
    phase_adj_valid = 1'b0;
    edge_at(100, 16'hC4AA, MZ_EARLY);
    do_reset();
    phase_adj = 16'h8000;
    phase_adj_valid = 1'b1;
    cyc();
    phase_adj_valid = 1'b0;
    edge_at(100, 16'hB567, MZ_EARLY);
    nominal_inc = 24'd83886;
    do_reset();
    phase_adj = 16'h7FFF;
    phase_adj_valid = 1'b1;
    cyc();
    phase_adj_valid = 1'b0;
    edge_at(100, 16'h0C7F, MZ_ONTIME);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_zones();
    test_unlock();
    test_carry_edge();
    test_back_to_back();
    test_enable();
    test_rate_change();
    test_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
